// File: rtl/verilog_bus_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : verilog_bus_driver_if
// Brief   : Upstream handshake and parallel-bus bundle for verilog_bus_driver.
//           Optional bus_parity present when VERILOG_BUS_DRIVER_PARITY_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
interface verilog_bus_driver_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  logic                         hold;
  logic [WIDTH-1:0]             bus_data;
  logic                         bus_enable;
  logic [$clog2(DEPTH+1)-1:0]   level;
`ifdef VERILOG_BUS_DRIVER_PARITY_EN
  logic                         bus_parity;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, bus_data, bus_enable, level, bus_parity
  );
  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, bus_data, bus_enable, level, bus_parity
  );
`else
  modport master (
    output in_valid, in_data, hold,
    input  in_ready, bus_data, bus_enable, level
  );
  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, bus_data, bus_enable, level
  );
`endif
endinterface
`default_nettype wire

// File: rtl/verilog_bus_driver.sv
`default_nettype none
// ============================================================================
// Module  : verilog_bus_driver
// Brief   : FIFO-buffered word driver emitting one strobed word per slot with a
//           programmable idle gap. Optional macro: VERILOG_BUS_DRIVER_PARITY_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module verilog_bus_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  verilog_bus_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int GW = 4;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [GW-1:0]    r_gap_cnt;
  logic [WIDTH-1:0] r_bus_data;
  logic             r_bus_enable;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;

  // Ready comes only from the registered level: a full FIFO refuses a push even
  // when the same edge pops.
  assign w_ready = (r_level < LW'(DEPTH));
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = (r_level != '0) && (r_gap_cnt == '0) && !bus.hold;

  assign bus.in_ready   = w_ready;
  assign bus.bus_data   = r_bus_data;
  assign bus.bus_enable = r_bus_enable;
  assign bus.level      = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_gap_cnt    <= '0;
      r_bus_data   <= '0;
      r_bus_enable <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_bus_data   <= r_mem[r_rd_ptr];
        r_bus_enable <= 1'b1;
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_gap_cnt    <= GW'(GAP);
      end else begin
        r_bus_enable <= 1'b0;
        if (r_gap_cnt != '0) begin
          r_gap_cnt <= r_gap_cnt - GW'(1);
        end
      end
    end
  end

`ifdef VERILOG_BUS_DRIVER_PARITY_EN
  logic r_bus_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_parity <= 1'b0;
    end else if (w_pop) begin
      r_bus_parity <= ^r_mem[r_rd_ptr];
    end
  end

  assign bus.bus_parity = r_bus_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_verilog_bus_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_verilog_bus_driver
// Brief   : Scoreboard bench for verilog_bus_driver (GAP=0 and GAP=2 instances).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_verilog_bus_driver;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  verilog_bus_driver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
  verilog_bus_driver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if2 ();

  verilog_bus_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );
  verilog_bus_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q2[$];

  // Stimulus drivers; accept tells the scoreboard whether this push will land.
  task automatic drive0(input logic v, input logic [WIDTH-1:0] d, input logic h, input bit accept);
    if0.in_valid = v;
    if0.in_data  = d;
    if0.hold     = h;
    if (v && accept) q0.push_back(d);
  endtask

  task automatic drive2(input logic v, input logic [WIDTH-1:0] d, input logic h, input bit accept);
    if2.in_valid = v;
    if2.in_data  = d;
    if2.hold     = h;
    if (v && accept) q2.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b0, '0, 1'b0, 1'b0);
    drive2(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (if0.bus_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b expected 0", if0.bus_enable); end
    n_cmp++; if (if0.bus_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", if0.bus_data); end
    n_cmp++; if (if0.level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", if0.level); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", if0.in_ready); end
    n_cmp++; if (if2.bus_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable2: got %b expected 0", if2.bus_enable); end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] exp;
    @(negedge clk); drive0(1'b1, 4'hA, 1'b0, 1'b1);
    @(negedge clk); drive0(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (if0.bus_enable !== 1'b0) begin n_err++; $display("FAIL single_early_enable: got %b expected 0", if0.bus_enable); end
    n_cmp++; if (if0.level !== 3'd1) begin n_err++; $display("FAIL single_level1: got %0d expected 1", if0.level); end
    @(negedge clk);
    n_cmp++;
    if (if0.bus_enable !== 1'b1) begin
      n_err++; $display("FAIL single_enable: got %b expected 1", if0.bus_enable);
    end else if (q0.size() == 0) begin
      n_err++; $display("FAIL single_scoreboard: got emit expected none");
    end else begin
      exp = q0.pop_front();
      n_cmp++; if (if0.bus_data !== exp) begin n_err++; $display("FAIL single_data: got %h expected %h", if0.bus_data, exp); end
    end
    n_cmp++; if (if0.level !== 3'd0) begin n_err++; $display("FAIL single_level0: got %0d expected 0", if0.level); end
    @(negedge clk);
    n_cmp++; if (if0.bus_enable !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got %b expected 0", if0.bus_enable); end
    n_cmp++; if (if0.bus_data !== 4'hA) begin n_err++; $display("FAIL single_hold_data: got %h expected a", if0.bus_data); end
  endtask

  // Fill under hold, refuse a push when full, then pop+push at full on release.
  task automatic test_fill_hold();
    logic [WIDTH-1:0] exp;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); drive0(1'b1, WIDTH'(i), 1'b1, 1'b1);
    end
    @(negedge clk);
    n_cmp++; if (if0.level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d expected 4", if0.level); end
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", if0.in_ready); end
    drive0(1'b1, 4'h5, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (if0.level !== 3'd4) begin n_err++; $display("FAIL full_refuse_level: got %0d expected 4", if0.level); end
    n_cmp++; if (if0.bus_enable !== 1'b0) begin n_err++; $display("FAIL hold_blocks: got %b expected 0", if0.bus_enable); end
    drive0(1'b1, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        drive0(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (if0.level !== 3'd3) begin n_err++; $display("FAIL full_pop_push_level: got %0d expected 3", if0.level); end
      end
      n_cmp++;
      if (if0.bus_enable !== 1'b1) begin
        n_err++; $display("FAIL drain_enable[%0d]: got %b expected 1", i, if0.bus_enable);
      end else if (q0.size() == 0) begin
        n_err++; $display("FAIL drain_scoreboard[%0d]: got emit expected none", i);
      end else begin
        exp = q0.pop_front();
        n_cmp++; if (if0.bus_data !== exp) begin n_err++; $display("FAIL drain_data[%0d]: got %h expected %h", i, if0.bus_data, exp); end
      end
    end
    @(negedge clk);
    n_cmp++; if (if0.bus_enable !== 1'b0) begin n_err++; $display("FAIL drain_done_enable: got %b expected 0", if0.bus_enable); end
    n_cmp++; if (if0.bus_data !== 4'h4) begin n_err++; $display("FAIL drain_hold_data: got %h expected 4", if0.bus_data); end
    n_cmp++; if (if0.level !== 3'd0) begin n_err++; $display("FAIL drain_level: got %0d expected 0", if0.level); end
  endtask

  task automatic test_gap();
    logic [WIDTH-1:0] exp;
    logic en_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk); drive2(1'b1, 4'h3, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) drive2(1'b1, 4'hC, 1'b0, 1'b1);
      if (j == 1) drive2(1'b0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (if2.bus_enable !== en_exp[j]) begin
        n_err++; $display("FAIL gap_enable[%0d]: got %b expected %b", j, if2.bus_enable, en_exp[j]);
      end else if (if2.bus_enable) begin
        if (q2.size() == 0) begin
          n_err++; $display("FAIL gap_scoreboard[%0d]: got emit expected none", j);
        end else begin
          exp = q2.pop_front();
          n_cmp++; if (if2.bus_data !== exp) begin n_err++; $display("FAIL gap_data[%0d]: got %h expected %h", j, if2.bus_data, exp); end
        end
      end else if (j == 2 || j == 3) begin
        n_cmp++; if (if2.bus_data !== 4'h3) begin n_err++; $display("FAIL gap_hold_data[%0d]: got %h expected 3", j, if2.bus_data); end
      end
    end
  endtask

  // Builds level=3 with gap_cnt=1, then resets between clock edges.
  task automatic test_async_reset();
    logic [WIDTH-1:0] exp;
    repeat (3) @(negedge clk);
    drive2(1'b1, 4'h6, 1'b0, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j <= 4) drive2(1'b1, WIDTH'(6 + j), 1'b0, 1'b1);
      else drive2(1'b0, '0, 1'b0, 1'b0);
      if (if2.bus_enable) begin
        if (q2.size() == 0) begin
          n_err++; $display("FAIL arst_scoreboard[%0d]: got emit expected none", j);
        end else begin
          exp = q2.pop_front();
          n_cmp++; if (if2.bus_data !== exp) begin n_err++; $display("FAIL arst_stream_data[%0d]: got %h expected %h", j, if2.bus_data, exp); end
        end
      end
    end
    n_cmp++; if (if2.level !== 3'd3) begin n_err++; $display("FAIL arst_pre_level: got %0d expected 3", if2.level); end
    n_cmp++; if (if2.bus_data !== 4'h7) begin n_err++; $display("FAIL arst_pre_data: got %h expected 7", if2.bus_data); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if2.bus_enable !== 1'b0) begin n_err++; $display("FAIL arst_enable: got %b expected 0", if2.bus_enable); end
    n_cmp++; if (if2.bus_data !== 4'h0) begin n_err++; $display("FAIL arst_data: got %h expected 0", if2.bus_data); end
    n_cmp++; if (if2.level !== 3'd0) begin n_err++; $display("FAIL arst_level: got %0d expected 0", if2.level); end
    n_cmp++; if (if2.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b expected 1", if2.in_ready); end
    q2.delete();
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_cmp++; if (if2.bus_enable !== 1'b0) begin n_err++; $display("FAIL arst_quiet[%0d]: got %b expected 0", j, if2.bus_enable); end
    end
    drive2(1'b1, 4'hB, 1'b0, 1'b1);
    @(negedge clk); drive2(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (if2.bus_enable !== 1'b1) begin
      n_err++; $display("FAIL arst_new_enable: got %b expected 1", if2.bus_enable);
    end else if (q2.size() == 0) begin
      n_err++; $display("FAIL arst_new_scoreboard: got emit expected none");
    end else begin
      exp = q2.pop_front();
      n_cmp++; if (if2.bus_data !== exp) begin n_err++; $display("FAIL arst_new_data: got %h expected %h", if2.bus_data, exp); end
    end
  endtask

`ifdef VERILOG_BUS_DRIVER_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] exp;
    logic par_exp [2] = '{1'b1, 1'b0};
    @(negedge clk); drive0(1'b1, 4'h7, 1'b0, 1'b1);
    @(negedge clk); drive0(1'b1, 4'h5, 1'b0, 1'b1);
    @(negedge clk); drive0(1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      if (j == 1) @(negedge clk);
      n_cmp++;
      if (if0.bus_enable !== 1'b1 || q0.size() == 0) begin
        n_err++; $display("FAIL parity_enable[%0d]: got %b expected 1", j, if0.bus_enable);
      end else begin
        exp = q0.pop_front();
        n_cmp++; if (if0.bus_data !== exp) begin n_err++; $display("FAIL parity_data[%0d]: got %h expected %h", j, if0.bus_data, exp); end
        n_cmp++; if (if0.bus_parity !== par_exp[j]) begin n_err++; $display("FAIL parity_bit[%0d]: got %b expected %b", j, if0.bus_parity, par_exp[j]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_hold();
    test_gap();
    test_async_reset();
`ifdef VERILOG_BUS_DRIVER_PARITY_EN
    test_parity();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/verilog_bus_driver.md
Name: verilog_bus_driver

Overview:
- Transmit-side counterpart of the gated bus-capture register bank used in the bus netlist tests.
- Accepts words over a valid/ready handshake and buffers them in a small FIFO.
- Drives them one per slot onto a parallel data bus with a qualifying enable strobe, which the capture bank ANDs with data before registering.
- Enforces a configurable idle gap between words and supports a hold input to pause draining.

Parameters:
- WIDTH, 4, bus/word width in bits (>=1).
- DEPTH, 4, FIFO depth in words; power of 2, >=2.
- GAP, 0, number of idle (enable-low) cycles forced after each emitted word; 0..15.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_data  input  WIDTH  upstream word.
- hold  input  1  when high, no word is popped or emitted.
- bus_data  output  WIDTH  registered bus word.
- bus_enable  output  1  registered strobe; high exactly one cycle per emitted word.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async, active-high):
  - FIFO emptied: read/write pointers 0, level=0.
  - gap counter=0.
  - bus_data=0, bus_enable=0, in_ready=1 on the first cycle after release.
  - Reset mid-operation discards all buffered words and any in-flight gap; no partial word is emitted.
- Push:
  - Occurs at a rising edge when in_valid && in_ready.
  - in_data is written at the write pointer; the pointer wraps DEPTH-1 -> 0.
- in_ready:
  - Combinational from registered level: high iff level < DEPTH.
  - When full, a push is refused even if a pop happens in the same cycle. No full-bypass.
- Pop/emit:
  - Condition at a rising edge: level != 0 && gap_cnt == 0 && !hold.
  - On that edge: bus_data <= head word, bus_enable <= 1, read pointer advances (wraps), gap_cnt <= GAP.
  - Otherwise bus_enable <= 0, and bus_data holds its last driven value (not zeroed).
- Gap counter:
  - Decrements by 1 each cycle while nonzero, regardless of hold.
  - Emission is allowed only on the edge after it reaches 0.
  - With GAP=0, back-to-back words are emitted on consecutive cycles.
- Empty bypass: none. A word pushed into an empty FIFO at edge k is emitted at edge k+1 at the earliest, so bus_enable is first high in the cycle after edge k+1. Minimum latency is 2 edges.
- Simultaneous push and pop:
  - Allowed whenever not full.
  - level is unchanged, and both pointers advance.
- Level update: level += push - pop, saturating never needed by construction; it never exceeds DEPTH or underflows.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- hold asserted while bus_enable is high does not retract the current strobe. It only blocks the next pop.

Optional Feature:
- Macro VERILOG_BUS_DRIVER_PARITY_EN.
- When defined:
  - Adds output bus_parity (1 bit), registered alongside bus_data.
  - Equals the XOR-reduction (even parity) of the word loaded on each emit; it holds with bus_data otherwise.
  - Reset value 0.
- When undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
1. Reset then push 4'hA with hold=0, GAP=0: bus_enable high for exactly one cycle 2 edges after the push, with bus_data=4'hA; level returns 0.
2. Push 4'h1,4'h2,4'h3,4'h4 with hold=1: level=4, in_ready=0; a 5th push of 4'h5 is refused. Release hold: words 1,2,3,4 are emitted on 4 consecutive cycles, and bus_data stays 4'h4 afterwards.
3. GAP=2, push 4'h3,4'hC back-to-back: enable pulses are separated by exactly 2 low cycles, and bus_data holds 4'h3 during the gap.
4. Full FIFO with pop and push asserted in the same cycle: push is refused (in_ready=0), and level goes 4 -> 3.
5. Assert rst asynchronously mid-stream with 3 words buffered and gap_cnt=1: outputs go to 0 immediately, level=0, and after release nothing is emitted until a new push.
6. With VERILOG_BUS_DRIVER_PARITY_EN, emit 4'h7 then 4'h5: bus_parity is 1 then 0.
